// File: rtl/video_out_write.sv
// Raster video output: pops 4-pixel words from a show-ahead FIFO and emits one pixel per clk
// with line_valid/frame_valid timing. Optional underflow counter: VIDEO_OUT_UNDERFLOW_CNT_EN.
module video_out_write #(
    parameter int p_WIDTH  = 640,
    parameter int p_HEIGHT = 480,
    parameter int p_LSYNC  = 160,
    parameter int p_FSYNC  = 40
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        fifo_empty,
    input  logic [31:0] fifo_data,
    output logic        fifo_r_e,
    output logic        line_valid,
    output logic        frame_valid,
    output logic [7:0]  pixel_out,
`ifdef VIDEO_OUT_UNDERFLOW_CNT_EN
    output logic [15:0] underflow_cnt,
`endif
    output logic        underflow
);

    localparam int COLS   = p_WIDTH + p_LSYNC;
    localparam int LINES  = p_HEIGHT + p_FSYNC;
    localparam int COL_W  = $clog2(COLS);
    localparam int LINE_W = $clog2(LINES);

    localparam logic [COL_W-1:0]  COL_LAST     = COL_W'(COLS - 1);
    localparam logic [COL_W-1:0]  COL_ACT_LAST = COL_W'(p_WIDTH - 1);
    localparam logic [LINE_W-1:0] LINE_LAST    = LINE_W'(LINES - 1);
    localparam logic [LINE_W-1:0] LINE_ACT_END = LINE_W'(p_HEIGHT - 1);
    localparam logic [LINE_W-1:0] LINE_RST     = LINE_W'(p_HEIGHT);

    typedef enum logic [1:0] {
        ST_ACTIVE,
        ST_HBLANK,
        ST_VBLANK
    } state_t;

    state_t            state_reg;
    logic [COL_W-1:0]  col_reg;
    logic [LINE_W-1:0] line_reg;
    logic [23:0]       shift_reg;
    logic              group_start;

    // A new 4-pixel group begins on every col that is a multiple of 4 inside the active area.
    assign group_start = (state_reg == ST_ACTIVE) && (col_reg[1:0] == 2'b00);
    assign fifo_r_e    = !RST && group_start && !fifo_empty;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_reg   <= ST_VBLANK;
            col_reg     <= '0;
            line_reg    <= LINE_RST;
            shift_reg   <= '0;
            line_valid  <= 1'b0;
            frame_valid <= 1'b0;
            pixel_out   <= 8'h00;
            underflow   <= 1'b0;
`ifdef VIDEO_OUT_UNDERFLOW_CNT_EN
            underflow_cnt <= 16'h0000;
`endif
        end else begin
            // Raster counters; the state register tracks the region the counters point at.
            if (col_reg == COL_LAST) begin
                col_reg <= '0;
                if (line_reg == LINE_LAST) begin
                    line_reg  <= '0;
                    state_reg <= ST_ACTIVE;
                end else begin
                    line_reg <= line_reg + LINE_W'(1);
                    if (state_reg == ST_HBLANK) begin
                        state_reg <= (line_reg == LINE_ACT_END) ? ST_VBLANK : ST_ACTIVE;
                    end
                end
            end else begin
                col_reg <= col_reg + COL_W'(1);
                if (state_reg == ST_ACTIVE && col_reg == COL_ACT_LAST) begin
                    state_reg <= ST_HBLANK;
                end
            end

            case (state_reg)
                ST_ACTIVE: begin
                    frame_valid <= 1'b1;
                    line_valid  <= 1'b1;
                    if (group_start) begin
                        if (!fifo_empty) begin
                            pixel_out <= fifo_data[31:24];
                            shift_reg <= fifo_data[23:0];
                        end else begin
                            // Starved group: emit zeros, keep the raster running.
                            pixel_out <= 8'h00;
                            shift_reg <= '0;
                            underflow <= 1'b1;
`ifdef VIDEO_OUT_UNDERFLOW_CNT_EN
                            if (underflow_cnt != 16'hFFFF) begin
                                underflow_cnt <= underflow_cnt + 16'h0001;
                            end
`endif
                        end
                    end else begin
                        pixel_out <= shift_reg[23:16];
                        shift_reg <= {shift_reg[15:0], 8'h00};
                    end
                end
                ST_HBLANK: begin
                    frame_valid <= 1'b1;
                    line_valid  <= 1'b0;
                    pixel_out   <= 8'h00;
                end
                default: begin
                    frame_valid <= 1'b0;
                    line_valid  <= 1'b0;
                    pixel_out   <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_video_out_write.sv
// Directed bench for video_out_write with a small raster (W=8, H=2, LSYNC=4, FSYNC=1).
// Expected timing is computed from the raster position; the FIFO is a bench-side queue.
module tb_video_out_write;

    localparam int W     = 8;
    localparam int H     = 2;
    localparam int LSYNC = 4;
    localparam int FSYNC = 1;
    localparam int ROW   = W + LSYNC;
    localparam int NLINE = H + FSYNC;

    logic        clk;
    logic        RST;
    logic        fifo_empty;
    logic [31:0] fifo_data;
    logic        fifo_r_e;
    logic        line_valid;
    logic        frame_valid;
    logic [7:0]  pixel_out;
    logic        underflow;
`ifdef VIDEO_OUT_UNDERFLOW_CNT_EN
    logic [15:0] underflow_cnt;
    int          exp_cnt;
`endif

    video_out_write #(
        .p_WIDTH (W),
        .p_HEIGHT(H),
        .p_LSYNC (LSYNC),
        .p_FSYNC (FSYNC)
    ) dut (
        .clk        (clk),
        .RST        (RST),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_r_e   (fifo_r_e),
        .line_valid (line_valid),
        .frame_valid(frame_valid),
        .pixel_out  (pixel_out),
`ifdef VIDEO_OUT_UNDERFLOW_CNT_EN
        .underflow_cnt(underflow_cnt),
`endif
        .underflow  (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_fail;
    int          p;          // raster position since the last reset release
    logic [31:0] q[$];
    logic [31:0] cur_word;
    logic        exp_uf;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (pos %0d)", tag, obs, exp, p);
        end
    endtask

    task automatic update_fifo();
        fifo_empty = (q.size() == 0);
        fifo_data  = (q.size() == 0) ? 32'hDEAD_BEEF : q[0];
    endtask

    task automatic push(input logic [31:0] w);
        q.push_back(w);
        update_fifo();
    endtask

    // One pixel clock: check the pop strobe before the edge, the registered outputs after it.
    task automatic do_cycle();
        int   ln, cl;
        logic act, grp, pop;
        ln  = (H + p / ROW) % NLINE;
        cl  = p % ROW;
        act = (ln < H) && (cl < W);
        grp = act && (cl % 4 == 0);
        pop = grp && (q.size() != 0);
        check_eq("fifo_r_e", {31'd0, fifo_r_e}, {31'd0, pop});
        if (grp) begin
            if (pop) begin
                cur_word = q[0];
                $display("pop   pos=%0d line=%0d col=%0d word=%h", p, ln, cl, cur_word);
            end else begin
                cur_word = 32'h0;
                exp_uf   = 1'b1;
`ifdef VIDEO_OUT_UNDERFLOW_CNT_EN
                exp_cnt++;
`endif
                $display("empty pos=%0d line=%0d col=%0d", p, ln, cl);
            end
        end
        @(posedge clk);
        #1;
        if (pop) begin
            void'(q.pop_front());
            update_fifo();
        end
        check_eq("frame_valid", {31'd0, frame_valid}, {31'd0, (ln < H)});
        check_eq("line_valid", {31'd0, line_valid}, {31'd0, act});
        check_eq("pixel_out", {24'd0, pixel_out},
                 act ? {24'd0, cur_word[8*(3-cl%4) +: 8]} : 32'h0);
        check_eq("underflow", {31'd0, underflow}, {31'd0, exp_uf});
`ifdef VIDEO_OUT_UNDERFLOW_CNT_EN
        check_eq("underflow_cnt", {16'd0, underflow_cnt}, exp_cnt);
`endif
        p++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_fv"}, {31'd0, frame_valid}, 32'h0);
        check_eq({tag, "_lv"}, {31'd0, line_valid}, 32'h0);
        check_eq({tag, "_pix"}, {24'd0, pixel_out}, 32'h0);
        check_eq({tag, "_uf"}, {31'd0, underflow}, 32'h0);
        check_eq({tag, "_re"}, {31'd0, fifo_r_e}, 32'h0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        p        = 0;
        cur_word = 32'h0;
        exp_uf   = 1'b0;
`ifdef VIDEO_OUT_UNDERFLOW_CNT_EN
        exp_cnt  = 0;
`endif
        RST = 1'b1;
        update_fifo();

        // Frames 1 and 2: continuous data, known byte order.
        push(32'h1122_3344); push(32'h5566_7788); push(32'h99AA_BBCC); push(32'hDDEE_FF01);
        push(32'h0102_0304); push(32'hF0E0_D0C0); push(32'h7F80_8182); push(32'hA5A5_5A5A);
        repeat (3) begin
            @(posedge clk);
            #1;
            check_reset_outputs("reset");
        end
        @(negedge clk);
        RST = 1'b0;
        for (int i = 0; i < 2 * NLINE * ROW; i++) do_cycle();

        // Frame 3: a single word, so line 0 starves from col 4 and line 1 fully.
        push(32'hC0FF_EE11);
        for (int i = 0; i < NLINE * ROW; i++) do_cycle();

        // Frame 4: data again; the underflow flag must stay set.
        push(32'h1020_3040); push(32'h5060_7080); push(32'h90A0_B0C0); push(32'hD0E0_F000);
        for (int i = 0; i < NLINE * ROW; i++) do_cycle();

        // Frame 5: stop at col 5 of line 1 and pulse reset asynchronously.
        push(32'h2468_ACE0); push(32'h1357_9BDF); push(32'h0F1E_2D3C); push(32'h4B5A_6978);
        for (int i = 0; i < ROW + ROW + 5; i++) do_cycle();
        push(32'hAB12_CD34); push(32'hEF56_0789); push(32'h3141_5926); push(32'h2718_2818);
        #2;
        RST = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        repeat (2) begin
            @(posedge clk);
            #1;
            check_reset_outputs("hold_rst");
            check_eq("no_pop_in_rst", q.size(), 32'd4);
        end
        @(negedge clk);
        RST      = 1'b0;
        p        = 0;
        exp_uf   = 1'b0;
        cur_word = 32'h0;
`ifdef VIDEO_OUT_UNDERFLOW_CNT_EN
        exp_cnt  = 0;
`endif
        for (int i = 0; i < NLINE * ROW; i++) do_cycle();
        check_eq("fifo_drained", q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
